// File: rtl/poly_pkg.sv
// Shared definitions for the sequential negacyclic polynomial multiplier.
// Holds the default coefficient width/count, the controller state encoding
// and the counter-width helper constant.
package poly_pkg;

  localparam int W_DEF = 8;                // coefficient width, arithmetic mod 2^W
  localparam int N_DEF = 4;                // coefficients per polynomial (power of 2, >= 2)
  localparam int LOGN  = $clog2(N_DEF);    // i/j counter width at the default N

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/poly_mult_seq_if.sv
// Operand/result handshake bundle for poly_mult_seq.
//   in_valid/in_ready   : operand transfer (a_flat, b_flat)
//   out_valid/out_ready : result transfer (c_flat)
// Coefficient k of each bus sits at [k*W +: W]; k=0 is the constant term.
// master = stimulus source / result consumer, slave = the multiplier.
interface poly_mult_seq_if
  import poly_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int N = N_DEF
);

  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] a_flat;
  logic [N*W-1:0] b_flat;
  logic           out_valid;
  logic           out_ready;
  logic [N*W-1:0] c_flat;

  modport master (
    output in_valid, a_flat, b_flat, out_ready,
    input  in_ready, out_valid, c_flat
  );

  modport slave (
    input  in_valid, a_flat, b_flat, out_ready,
    output in_ready, out_valid, c_flat
  );

endinterface

// File: rtl/poly_mac.sv
// Combinational multiply-accumulate stage: acc_out = acc_in +/- a*b mod 2^W.
//   a, b    : coefficient operands
//   acc_in  : current accumulator value
//   negate  : 1 subtracts the product (negacyclic wrap term), 0 adds it
//   acc_out : updated accumulator value
module poly_mac
  import poly_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] acc_in,
  input  logic         negate,
  output logic [W-1:0] acc_out
);

  logic [W-1:0] prod;

  always_comb begin
    // Only the low W bits of the product matter, so the product is sized to W.
    prod    = a * b;
    acc_out = negate ? (acc_in - prod) : (acc_in + prod);
  end

endmodule

// File: rtl/poly_mult_seq.sv
// Sequential multiplier computing C(x) = A(x)*B(x) mod (x^N + 1), coefficients
// mod 2^W, with one MAC per clock through a single poly_mac.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : operand and result handshakes (poly_mult_seq_if.slave)
// Operands are latched on acceptance; N*N MAC edges later the result appears
// on c_flat with out_valid held until out_ready.
module poly_mult_seq
  import poly_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int N = N_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  poly_mult_seq_if.slave bus
);

  localparam int            CW   = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t         state;
  logic [N*W-1:0] a_reg;
  logic [N*W-1:0] b_reg;
  logic [W-1:0]   acc [N];
  logic [CW-1:0]  i;
  logic [CW-1:0]  j;

  logic [CW:0]    idx_sum;
  logic [CW-1:0]  k;
  logic           negate;
  logic [W-1:0]   mac_a;
  logic [W-1:0]   mac_b;
  logic [W-1:0]   mac_acc;
  logic [W-1:0]   mac_out;
  logic [W-1:0]   acc_next [N];
  logic [N*W-1:0] acc_next_flat;

  // Target coefficient is (i+j) mod N; the carry out of the counter-width sum
  // flags i+j >= N, where x^N = -1 turns the add into a subtract.
  always_comb begin
    // NOTE: every combinational output is assigned on every path, so no latches.
    idx_sum = {1'b0, i} + {1'b0, j};
    k       = idx_sum[CW-1:0];
    negate  = idx_sum[CW];
    mac_a   = a_reg[i*W +: W];
    mac_b   = b_reg[j*W +: W];
    mac_acc = acc[k];
  end

  poly_mac #(.W(W)) u_mac (
    .a      (mac_a),
    .b      (mac_b),
    .acc_in (mac_acc),
    .negate (negate),
    .acc_out(mac_out)
  );

  // Accumulator bank after this edge's MAC; also feeds c_flat on the final
  // pair so the last product is not lost.
  always_comb begin
    for (int n = 0; n < N; n++) begin
      acc_next[n]                = (CW'(n) == k) ? mac_out : acc[n];
      acc_next_flat[n*W +: W]    = acc_next[n];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the accumulator array is small and must read 0 out of reset, so
      // it is reset explicitly rather than treated as an uninitialised RAM.
      state         <= IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.c_flat    <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      i             <= '0;
      j             <= '0;
      for (int n = 0; n < N; n++) acc[n] <= '0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every register
      // sees pre-edge values regardless of statement order.
      case (state)
        IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            a_reg        <= bus.a_flat;
            b_reg        <= bus.b_flat;
            i            <= '0;
            j            <= '0;
            for (int n = 0; n < N; n++) acc[n] <= '0;
            bus.in_ready <= 1'b0;
            state        <= CALC;
          end
        end

        CALC: begin
          for (int n = 0; n < N; n++) acc[n] <= acc_next[n];
          if (j == LAST) begin
            j <= '0;
            if (i == LAST) begin
              i             <= '0;
              bus.c_flat    <= acc_next_flat;
              bus.out_valid <= 1'b1;
              state         <= DONE;
            end else begin
              i <= i + 1'b1;
            end
          end else begin
            j <= j + 1'b1;
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end

        default: begin
          bus.out_valid <= 1'b0;
          bus.in_ready  <= 1'b1;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_poly_mult_seq.sv
// Self-checking bench for poly_mult_seq. A transaction-level model (plain
// negacyclic convolution plus a latency countdown) predicts in_ready,
// out_valid and c_flat every cycle; directed operations pin literal results,
// latency, backpressure and mid-computation reset; a randomized phase follows.
module tb_poly_mult_seq;
  import poly_pkg::*;

  localparam int W = 8;
  localparam int N = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  poly_mult_seq_if #(.W(W), .N(N)) bus ();

  poly_mult_seq #(.W(W), .N(N)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // C = A*B mod (x^N + 1), each coefficient mod 2^W, by direct convolution.
  function automatic logic [N*W-1:0] negacyclic(input logic [N*W-1:0] a, input logic [N*W-1:0] b);
    int c [N];
    logic [N*W-1:0] r;
    for (int n = 0; n < N; n++) c[n] = 0;
    for (int x = 0; x < N; x++)
      for (int y = 0; y < N; y++) begin
        int p;
        p = int'(a[x*W +: W]) * int'(b[y*W +: W]);
        if (x + y < N) c[x + y]     += p;
        else           c[x + y - N] -= p;
      end
    for (int n = 0; n < N; n++) r[n*W +: W] = W'(c[n]);
    return r;
  endfunction

  // Transaction-level model: idle -> N*N cycles busy -> result held until taken.
  int             m_cnt;
  logic           m_ready;
  logic           m_ov;
  logic [N*W-1:0] m_c;
  logic [N*W-1:0] m_pend;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt   <= 0;
      m_ready <= 1'b1;
      m_ov    <= 1'b0;
      m_c     <= '0;
      m_pend  <= '0;
    end else if (m_ready && bus.in_valid) begin
      m_ready <= 1'b0;
      m_cnt   <= N * N;
      m_pend  <= negacyclic(bus.a_flat, bus.b_flat);
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_ov <= 1'b1;
        m_c  <= m_pend;
      end
    end else if (m_ov && bus.out_ready) begin
      m_ov    <= 1'b0;
      m_ready <= 1'b1;
    end
  end

  always @(negedge clk) begin
    check("cyc_in_ready",  bus.in_ready,  m_ready);
    check("cyc_out_valid", bus.out_valid, m_ov);
    check("cyc_c_flat",    bus.c_flat,    m_c);
  end

  task automatic wait_ready(input string name);
    int guard = 0;
    while (!bus.in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check({name, "_ready_wait"}, bus.in_ready, 1'b1);
  endtask

  // One operation with literal expectation; hold>0 keeps out_ready low that
  // many cycles after out_valid, pulsing in_valid meanwhile.
  task automatic do_op(input string name, input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                       input logic [N*W-1:0] exp_c, input int hold);
    int lat = 0;
    wait_ready(name);
    bus.a_flat    = a;
    bus.b_flat    = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = (hold == 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    while (!bus.out_valid && lat < 100) begin
      check({name, "_in_ready_busy"}, bus.in_ready, 1'b0);
      bus.a_flat = $urandom;
      bus.b_flat = $urandom;
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_latency"}, lat, N * N);
    check({name, "_c_flat"}, bus.c_flat, exp_c);
    check({name, "_in_ready_done"}, bus.in_ready, 1'b0);
    if (hold > 0) begin
      repeat (hold) begin
        bus.in_valid = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        check({name, "_hold_valid"}, bus.out_valid, 1'b1);
        check({name, "_hold_c"}, bus.c_flat, exp_c);
        check({name, "_hold_in_ready"}, bus.in_ready, 1'b0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check({name, "_drain_valid"}, bus.out_valid, 1'b0);
    check({name, "_drain_ready"}, bus.in_ready, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.a_flat    = '0;
    bus.b_flat    = '0;
    bus.out_ready = 1'b1;

    // Hand-computed values pin the model itself.
    check("model_identity", negacyclic(32'h04030201, 32'h00000001), 32'h04030201);
    check("model_wrap",     negacyclic(32'h01000000, 32'h00000100), 32'h000000FF);
    check("model_ones",     negacyclic(32'h01010101, 32'h01010101), 32'h040200FE);

    @(negedge clk);
    check("rst_in_ready",  bus.in_ready,  1'b1);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_c_flat",    bus.c_flat,    '0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("identity", 32'h04030201, 32'h00000001, 32'h04030201, 0);
    do_op("wrap",     32'h01000000, 32'h00000100, 32'h000000FF, 0);
    do_op("ones",     32'h01010101, 32'h01010101, 32'h040200FE, 0);
    do_op("overflow", 32'h000000FF, 32'h000000FF, 32'h00000001, 0);
    do_op("backpres", 32'h01010101, 32'h01010101, 32'h040200FE, 20);

    // Reset after the 7th MAC edge of an operation.
    wait_ready("midrst");
    bus.a_flat   = 32'h04030201;
    bus.b_flat   = 32'h01010101;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 1'b0);
    check("midrst_in_ready",  bus.in_ready,  1'b1);
    check("midrst_c_flat",    bus.c_flat,    '0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op("after_rst", 32'h00000002, 32'h00000003, 32'h00000006, 0);

    // Randomized traffic with random backpressure and one async reset.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.a_flat    = $urandom;
      bus.b_flat    = $urandom;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (cyc == 700) begin
        #2 rst_n = 1'b0;
      end else if (cyc == 701) begin
        #2 rst_n = 1'b1;
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
